hex_display_arbiter: RTL and testbench

- Shares the board's six-digit seven-segment display between NREQ independent requesters (debug counters, tensor-op status, error codes).
- Each requester offers a 24-bit hex value (six nibbles) plus a 6-bit blank mask over a valid/ready handshake.
- A round-robin scheduler grants ownership for a minimum dwell time, latches the winner's data and drives the nibble/blank inputs of the existing seven-segment display driver.

---
 rtl/hex_display_arbiter.sv | 145 ++++++++++++++
 tb/tb_hex_display_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing a six-digit hex display among NREQ requesters.
// Optional HEX_DISPLAY_ARBITER_OVERRIDE_EN adds a combinational force path.
module hex_display_arbiter #(
  parameter int NREQ         = 4,
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*24-1:0]       req_value,
  input  logic [NREQ*6-1:0]        req_blank,
  output logic [NREQ-1:0]          req_ready,
  output logic [3:0]               BCH5,
  output logic [3:0]               BCH4,
  output logic [3:0]               BCH3,
  output logic [3:0]               BCH2,
  output logic [3:0]               BCH1,
  output logic [3:0]               BCH0,
  output logic [5:0]               blank,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     owner_valid
`ifdef HEX_DISPLAY_ARBITER_OVERRIDE_EN
  ,
  input  logic                     force_en,
  input  logic [23:0]              force_value,
  input  logic [5:0]               force_blank
`endif
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(DWELL_CYCLES - 1);

  typedef enum logic {
    IDLE,
    DWELL
  } state_t;

  state_t        state, state_n;
  logic          run;
  logic [CW-1:0] cnt;
  logic [23:0]   val_q;
  logic [5:0]    blank_q;

  logic          any;
  logic [OW-1:0] win;
  logic          expire;
  logic          load_new;
  logic          upd;
  logic [OW-1:0] sel;

  // Search starts just past the current owner and wraps.
  always_comb begin
    int idx;
    any = 1'b0;
    win = owner;
    idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(owner) + k) % NREQ;
      if (!any && req_valid[idx]) begin
        any = 1'b1;
        win = idx[OW-1:0];
      end
    end
  end

  assign expire   = (cnt == '0);
  assign load_new = run && any &&
                    ((state == IDLE) || expire);
  assign upd      = run && (state == DWELL) &&
                    !expire && req_valid[owner];
  assign sel      = load_new ? win : owner;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (run && any)     state_n = DWELL;
      DWELL: if (expire && !any) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (run) begin
      unique case (state)
        IDLE: if (any) req_ready[win] = 1'b1;
        DWELL: begin
          if (expire) begin
            if (any) req_ready[win] = 1'b1;
          end else begin
            req_ready[owner] = req_valid[owner];
          end
        end
        default: req_ready = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run         <= 1'b0;
      cnt         <= '0;
      val_q       <= '0;
      blank_q     <= 6'h3F;
      owner       <= '0;
      owner_valid <= 1'b0;
    end else begin
      run <= 1'b1;
      if (load_new || upd) begin
        val_q   <= req_value[int'(sel)*24 +: 24];
        blank_q <= req_blank[int'(sel)*6 +: 6];
      end
      if (load_new) begin
        owner       <= win;
        owner_valid <= 1'b1;
        cnt         <= RELOAD;
      end else if (state == DWELL) begin
        if (!expire) cnt <= cnt - 1'b1;
        else         owner_valid <= 1'b0;
      end
    end
  end

  always_comb begin
`ifdef HEX_DISPLAY_ARBITER_OVERRIDE_EN
    if (force_en) begin
      {BCH5, BCH4, BCH3, BCH2, BCH1, BCH0} = force_value;
      blank = force_blank;
    end else begin
      {BCH5, BCH4, BCH3, BCH2, BCH1, BCH0} = val_q;
      blank = blank_q;
    end
`else
    {BCH5, BCH4, BCH3, BCH2, BCH1, BCH0} = val_q;
    blank = blank_q;
`endif
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter, NREQ=4, DWELL_CYCLES=4.
// Covers reset, single grant, round robin, owner update, expiry, override.
module tb_hex_display_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [95:0] req_value;
  logic [23:0] req_blank;
  logic [3:0]  req_ready;
  logic [3:0]  BCH5, BCH4, BCH3, BCH2, BCH1, BCH0;
  logic [5:0]  blank;
  logic [1:0]  owner;
  logic        owner_valid;
`ifdef HEX_DISPLAY_ARBITER_OVERRIDE_EN
  logic        force_en;
  logic [23:0] force_value;
  logic [5:0]  force_blank;
`endif

  int checks = 0;
  int failures = 0;

  wire [23:0] disp = {BCH5, BCH4, BCH3, BCH2, BCH1, BCH0};

  hex_display_arbiter #(
    .NREQ(4),
    .DWELL_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_value(req_value),
    .req_blank(req_blank),
    .req_ready(req_ready),
    .BCH5(BCH5),
    .BCH4(BCH4),
    .BCH3(BCH3),
    .BCH2(BCH2),
    .BCH1(BCH1),
    .BCH0(BCH0),
    .blank(blank),
    .owner(owner),
    .owner_valid(owner_valid)
`ifdef HEX_DISPLAY_ARBITER_OVERRIDE_EN
    ,
    .force_en(force_en),
    .force_value(force_value),
    .force_blank(force_blank)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (owner_valid && n < 10) begin
      tick();
      n++;
    end
    if (owner_valid) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout owner_valid still 1");
    end
  endtask

  task automatic test_reset();
    req_valid = 4'b0100;
    req_value = '0;
    req_blank = '0;
    req_value[2*24 +: 24] = 24'h123456;
    reset_n = 1'b0;
    repeat (2) tick();
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL rst_ready got %b exp 0000", req_ready);
    end
    checks++;
    if (disp !== 24'h0 || blank !== 6'h3F) begin
      failures++;
      $display("FAIL rst_disp got %h/%h exp 000000/3f", disp, blank);
    end
    checks++;
    if (owner_valid !== 1'b0 || owner !== 2'd0) begin
      failures++;
      $display("FAIL rst_owner got %b/%0d exp 0/0", owner_valid, owner);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL post_rst_ready got %b exp 0000", req_ready);
    end
  endtask

  task automatic test_single();
    tick();
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single_ready got %b exp 0100", req_ready);
    end
    checks++;
    if (disp !== 24'h0 || blank !== 6'h3F) begin
      failures++;
      $display("FAIL single_pre got %h/%h exp 000000/3f", disp, blank);
    end
    tick();
    req_valid = 4'b0000;
    #1;
    checks++;
    if (disp !== 24'h123456 || blank !== 6'h00) begin
      failures++;
      $display("FAIL single_disp got %h/%h exp 123456/00", disp, blank);
    end
    checks++;
    if (owner !== 2'd2 || owner_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_owner got %0d/%b exp 2/1", owner, owner_valid);
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL single_ready_drop got %b exp 0000", req_ready);
    end
    drain();
  endtask

  task automatic test_round_robin();
    logic [23:0] rv [4];
    int order [4];
    logic [23:0] prev;
    rv = '{24'h0A0A0A, 24'h1B1B1B, 24'h2C2C2C, 24'h3C3C3C};
    order = '{0, 1, 3, 0};
    for (int i = 0; i < 4; i++) req_value[i*24 +: 24] = rv[i];
    req_valid = 4'b1011;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL rr_first_ready got %b exp 1000", req_ready);
    end
    tick();
    checks++;
    if (owner !== 2'd3 || disp !== 24'h3C3C3C) begin
      failures++;
      $display("FAIL rr_first got %0d/%h exp 3/3c3c3c", owner, disp);
    end
    prev = 24'h3C3C3C;
    for (int g = 0; g < 4; g++) begin
      repeat (3) tick();
      checks++;
      if (req_ready !== (4'b0001 << order[g]) || disp !== prev) begin
        failures++;
        $display("FAIL rr_grant%0d ready %b disp %h exp %b %h",
                 g, req_ready, disp, 4'b0001 << order[g], prev);
      end
      tick();
      checks++;
      if (owner !== 2'(order[g]) || disp !== rv[order[g]]) begin
        failures++;
        $display("FAIL rr_owner%0d got %0d/%h exp %0d/%h",
                 g, owner, disp, order[g], rv[order[g]]);
      end
      prev = rv[order[g]];
    end
    req_valid = 4'b0000;
    drain();
  endtask

  task automatic test_owner_update();
    req_valid = 4'b0010;
    req_value[1*24 +: 24] = 24'h111111;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL upd_grant got %b exp 0010", req_ready);
    end
    tick();
    req_value[1*24 +: 24] = 24'hAAAAAA;
    req_value[2*24 +: 24] = 24'h222222;
    req_valid = 4'b0110;
    #1;
    checks++;
    if (req_ready !== 4'b0010 || owner !== 2'd1) begin
      failures++;
      $display("FAIL upd_ready1 got %b/%0d exp 0010/1", req_ready, owner);
    end
    tick();
    req_value[1*24 +: 24] = 24'hBBBBBB;
    checks++;
    if (disp !== 24'hAAAAAA) begin
      failures++;
      $display("FAIL upd_aa got %h exp aaaaaa", disp);
    end
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL upd_ready2 got %b exp 0010", req_ready);
    end
    tick();
    req_valid = 4'b0100;
    checks++;
    if (disp !== 24'hBBBBBB) begin
      failures++;
      $display("FAIL upd_bb got %h exp bbbbbb", disp);
    end
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL upd_wait got %b exp 0000", req_ready);
    end
    tick();
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL upd_expire got %b exp 0100", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    checks++;
    if (owner !== 2'd2 || disp !== 24'h222222) begin
      failures++;
      $display("FAIL upd_handover got %0d/%h exp 2/222222", owner, disp);
    end
  endtask

  task automatic test_expiry();
    repeat (3) tick();
    checks++;
    if (owner_valid !== 1'b1) begin
      failures++;
      $display("FAIL exp_early got %b exp 1", owner_valid);
    end
    tick();
    checks++;
    if (owner_valid !== 1'b0 || owner !== 2'd2 || disp !== 24'h222222) begin
      failures++;
      $display("FAIL exp_idle got %b/%0d/%h exp 0/2/222222",
               owner_valid, owner, disp);
    end
    req_valid = 4'b0001;
    req_value[0*24 +: 24] = 24'h0F0E0D;
    req_blank[0*6 +: 6] = 6'h21;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL exp_new_ready got %b exp 0001", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    checks++;
    if (owner !== 2'd0 || owner_valid !== 1'b1 ||
        disp !== 24'h0F0E0D || blank !== 6'h21) begin
      failures++;
      $display("FAIL exp_new got %0d/%b/%h/%h exp 0/1/0f0e0d/21",
               owner, owner_valid, disp, blank);
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b1000;
    repeat (3) tick();
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL mid_grant got %b exp 1000", req_ready);
    end
    tick();
    tick();
    checks++;
    if (owner !== 2'd3) begin
      failures++;
      $display("FAIL mid_owner got %0d exp 3", owner);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (owner !== 2'd0 || owner_valid !== 1'b0 ||
        disp !== 24'h0 || blank !== 6'h3F || req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL mid_rst got %0d/%b/%h/%h/%b exp 0/0/000000/3f/0000",
               owner, owner_valid, disp, blank, req_ready);
    end
    tick();
    reset_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL mid_post got %b exp 0000", req_ready);
    end
    tick();
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL mid_rerun got %b exp 1000", req_ready);
    end
    req_valid = 4'b0000;
    tick();
  endtask

`ifdef HEX_DISPLAY_ARBITER_OVERRIDE_EN
  task automatic test_force();
    force_en = 1'b1;
    force_value = 24'hDEAD00;
    force_blank = 6'h00;
    #1;
    checks++;
    if (disp !== 24'hDEAD00 || blank !== 6'h00) begin
      failures++;
      $display("FAIL force_on got %h/%h exp dead00/00", disp, blank);
    end
    req_valid = 4'b0010;
    req_value[1*24 +: 24] = 24'h111111;
    req_blank[1*6 +: 6] = 6'h00;
    tick();
    req_valid = 4'b0000;
    checks++;
    if (owner !== 2'd1 || owner_valid !== 1'b1 || disp !== 24'hDEAD00) begin
      failures++;
      $display("FAIL force_arb got %0d/%b/%h exp 1/1/dead00",
               owner, owner_valid, disp);
    end
    force_en = 1'b0;
    #1;
    checks++;
    if (disp !== 24'h111111) begin
      failures++;
      $display("FAIL force_off got %h exp 111111", disp);
    end
  endtask
`endif

  initial begin
`ifdef HEX_DISPLAY_ARBITER_OVERRIDE_EN
    force_en = 1'b0;
    force_value = '0;
    force_blank = '0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_owner_update();
    test_expiry();
    test_reset_mid();
`ifdef HEX_DISPLAY_ARBITER_OVERRIDE_EN
    test_force();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
